// File: rtl/fmul32_pkg.sv
// Shared types and constants for the FMUL32 normalize/round stage.
package fmul32_pkg;

    localparam int unsigned PROD_W  = 48;
    localparam int unsigned EXP_W   = 10;
    localparam int unsigned SIG_W   = 24;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned RES_W   = 32;

    localparam logic [RES_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]       EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CLS_NAN  = 3'd0,
        CLS_INF  = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_OVF  = 3'd3,
        CLS_DEN  = 3'd4,
        CLS_NRM  = 3'd5
    } cls_e;

    // Aligned significand with guard/sticky, handed from stage 1 to stage 2
    typedef struct packed {
        logic             sign;
        cls_e             cls;
        logic [7:0]       exp;
        logic [SIG_W-1:0] sig;
        logic             g;
        logic             s;
    } align_t;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             overflow;
        logic             underflow;
        logic             inexact;
    } res_t;

endpackage

// File: rtl/fmul32_norm_round_if.sv
// Input beat and result handshake bundle of the normalize/round stage.
interface fmul32_norm_round_if;

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_sign;
    logic [fmul32_pkg::PROD_W-1:0]   in_mant;
    logic [fmul32_pkg::EXP_W-1:0]    exp_res_tmp;
    logic [fmul32_pkg::SHAMT_W-1:0]  denorm_shift;
    logic                            prev_inf;
    logic                            prev_overflow;
    logic                            in_nan;
    logic                            in_inf;
    logic                            in_zero;
    logic                            out_valid;
    logic                            out_ready;
    logic [fmul32_pkg::RES_W-1:0]    out_result;
    logic                            out_overflow;
    logic                            out_underflow;
    logic                            out_inexact;

    modport master (
        output in_valid, in_sign, in_mant, exp_res_tmp, denorm_shift,
               prev_inf, prev_overflow, in_nan, in_inf, in_zero, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_mant, exp_res_tmp, denorm_shift,
               prev_inf, prev_overflow, in_nan, in_inf, in_zero, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact
    );

endinterface

// File: rtl/fmul32_sticky_shr.sv
// Combinational 48-bit logical right shift that also ORs all discarded bits.
module fmul32_sticky_shr
    import fmul32_pkg::*;
(
    input  logic [PROD_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [PROD_W-1:0]  data_c_o,
    output logic               sticky_c_o
);

    localparam logic [PROD_W-1:0] ONES = '1;

    // Shifts of PROD_W or more give zero data and an all-ones mask
    assign data_c_o   = data_i >> shamt_i;
    assign sticky_c_o = |(data_i & ~(ONES << shamt_i));

endmodule

// File: rtl/fmul32_norm_round.sv
// Final FMUL32 stage: align/denormalize (stage 1), round-to-nearest-even and pack (stage 2).
module fmul32_norm_round
    import fmul32_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fmul32_norm_round_if.slave  bus
);

    logic               s1_valid_q, s1_valid_d;
    logic               s2_valid_q, s2_valid_d;
    logic               s1_adv, s2_adv;
    align_t             s1_q, s1_d;
    res_t               res_q, res_d;

    cls_e               cls;
    logic [SHAMT_W-1:0] shamt;
    logic [7:0]         exp_adj;
    logic [PROD_W-1:0]  shr;
    logic               shr_sticky;
    logic               unused_bits;

    logic               up;
    logic [SIG_W:0]     sum;
    logic [7:0]         exp_inc;

    assign s2_adv       = ~s2_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign s1_valid_d   = s1_adv ? bus.in_valid : s1_valid_q;
    assign s2_valid_d   = s2_adv ? s1_valid_q   : s2_valid_q;

    assign bus.in_ready      = s1_adv;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_result    = res_q.result;
    assign bus.out_overflow  = res_q.overflow;
    assign bus.out_underflow = res_q.underflow;
    assign bus.out_inexact   = res_q.inexact;

    // Stage 1 classification and alignment shift amount
    always_comb begin
        cls     = CLS_NRM;
        shamt   = '0;
        exp_adj = bus.exp_res_tmp[7:0];
        if (bus.in_nan) begin
            cls = CLS_NAN;
        end else if (bus.in_inf) begin
            cls = CLS_INF;
        end else if (bus.in_zero) begin
            cls = CLS_ZERO;
        end else if (bus.prev_overflow | bus.prev_inf) begin
            cls = CLS_OVF;
        end else if (bus.denorm_shift != '0) begin
            cls     = CLS_DEN;
            shamt   = bus.denorm_shift;
            exp_adj = '0;
        end else begin
            if (bus.in_mant[PROD_W-1]) begin
                shamt   = SHAMT_W'(1);
                exp_adj = bus.exp_res_tmp[7:0] + 8'd1;
            end
            if (exp_adj == EXP_MAX) begin
                cls = CLS_OVF;
            end
        end
    end

    fmul32_sticky_shr u_shr (
        .data_i     (bus.in_mant),
        .shamt_i    (shamt),
        .data_c_o   (shr),
        .sticky_c_o (shr_sticky)
    );

    // Bit 47 is always clear after alignment; exponent sign/overflow bits are pre-decoded upstream
    assign unused_bits = ^{shr[PROD_W-1], bus.exp_res_tmp[EXP_W-1:8]};

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_sign;
        s1_d.cls  = cls;
        s1_d.exp  = exp_adj;
        s1_d.sig  = shr[46:23];
        s1_d.g    = shr[22];
        s1_d.s    = (|shr[21:0]) | shr_sticky;
    end

    // Stage 2 round-to-nearest-even and packing
    always_comb begin
        up      = s1_q.g & (s1_q.s | s1_q.sig[0]);
        sum     = {1'b0, s1_q.sig} + (SIG_W+1)'(up);
        exp_inc = s1_q.exp + 8'd1;
        res_d   = '0;
        case (s1_q.cls)
            CLS_NAN:  res_d.result = QNAN;
            CLS_INF:  res_d.result = {s1_q.sign, EXP_MAX, 23'd0};
            CLS_ZERO: res_d.result = {s1_q.sign, 31'd0};
            CLS_OVF: begin
                res_d.result   = {s1_q.sign, EXP_MAX, 23'd0};
                res_d.overflow = 1'b1;
                res_d.inexact  = 1'b1;
            end
            CLS_DEN: begin
                // Rounding can carry into the hidden bit (exp 1) or past it (exp 2)
                res_d.result    = {s1_q.sign, (sum[SIG_W] ? 8'd2 : {7'd0, sum[23]}), sum[22:0]};
                res_d.underflow = s1_q.g | s1_q.s;
                res_d.inexact   = s1_q.g | s1_q.s;
            end
            default: begin
                res_d.inexact = s1_q.g | s1_q.s;
                if (sum[SIG_W]) begin
                    if (exp_inc == EXP_MAX) begin
                        res_d.result   = {s1_q.sign, EXP_MAX, 23'd0};
                        res_d.overflow = 1'b1;
                    end else begin
                        res_d.result = {s1_q.sign, exp_inc, sum[23:1]};
                    end
                end else begin
                    res_d.result = {s1_q.sign, s1_q.exp, sum[22:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            res_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_adv && bus.in_valid) begin
                s1_q <= s1_d;
            end
            if (s2_adv && s1_valid_q) begin
                res_q <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_fmul32_norm_round.sv
// Self-checking bench: directed cases plus randomized traffic against a remainder-based rounding model.
module tb_fmul32_norm_round;

    logic clk;
    logic rst_n;

    fmul32_norm_round_if bif ();

    fmul32_norm_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cnt = 0;
    bit          chk_lat = 1'b1;
    bit          prev_stall = 1'b0;
    logic [34:0] prev_obs = '0;
    logic [34:0] last_out = '0;
    logic        last_in_ready = 1'b0;
    logic [34:0] exp_q[$];
    int          acc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {result, overflow, underflow, inexact} from exact integer remainder arithmetic
    function automatic logic [34:0] model(input logic sign, input logic [47:0] mant,
                                          input logic [9:0] e10, input logic [7:0] dsh,
                                          input logic pinf, input logic povf,
                                          input logic nan, input logic inf, input logic zero);
        longint unsigned m, q, rem, keep, low, r;
        int  sh, e;
        bit  den, inx, up;
        if (nan)  return {32'h7FC0_0000, 3'b000};
        if (inf)  return {sign, 8'hFF, 23'd0, 3'b000};
        if (zero) return {sign, 31'd0, 3'b000};
        if (pinf || povf) return {sign, 8'hFF, 23'd0, 3'b101};
        m   = 64'(mant);
        den = (dsh != 8'd0);
        if (den) begin
            sh = int'(dsh);
            e  = 0;
        end else begin
            sh = mant[47] ? 1 : 0;
            e  = int'(e10[7:0]) + sh;
            if (e >= 255) return {sign, 8'hFF, 23'd0, 3'b101};
        end
        if (sh >= 48) begin
            q   = 0;
            rem = m;
        end else begin
            q   = m >> sh;
            rem = m - (q << sh);
        end
        keep = q >> 23;
        low  = q & 64'h7F_FFFF;
        inx  = (rem != 0) || (low != 0);
        if (low > 64'h40_0000)       up = 1'b1;
        else if (low == 64'h40_0000) up = (rem != 0) || keep[0];
        else                         up = 1'b0;
        r = keep + 64'(up);
        if (r >= (64'd1 << 24)) begin
            r = r >> 1;
            e = e + 1;
        end
        if (den && r >= (64'd1 << 23)) e = e + 1;
        if (!den && e >= 255) return {sign, 8'hFF, 23'd0, 3'b101};
        return {sign, 8'(e), 23'(r), 1'b0, den && inx, inx};
    endfunction

    // One cycle: sample mid-cycle, score, then advance to the next falling edge
    task automatic step();
        logic [34:0] obs, expv;
        int          acc;
        #1;
        obs = {bif.out_result, bif.out_overflow, bif.out_underflow, bif.out_inexact};
        last_in_ready = bif.in_ready;
        if (prev_stall) begin
            chk("stall_valid", 64'(bif.out_valid), 64'd1);
            chk("stall_hold", 64'(obs), 64'(prev_obs));
        end
        if (bif.out_valid && bif.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(bif.out_valid), 64'd0);
            end else begin
                expv = exp_q.pop_front();
                acc  = acc_q.pop_front();
                chk("result", 64'(obs), 64'(expv));
                if (chk_lat) chk("latency", 64'(cyc - acc), 64'd2);
                last_out = obs;
            end
        end
        prev_stall = bif.out_valid && !bif.out_ready;
        prev_obs   = obs;
        if (bif.in_valid && bif.in_ready) begin
            exp_q.push_back(model(bif.in_sign, bif.in_mant, bif.exp_res_tmp, bif.denorm_shift,
                                  bif.prev_inf, bif.prev_overflow, bif.in_nan, bif.in_inf,
                                  bif.in_zero));
            acc_q.push_back(cyc);
            acc_cnt++;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input logic sign, input logic [47:0] mant, input logic [9:0] e10,
                            input logic [7:0] dsh, input logic pinf, input logic povf,
                            input logic nan, input logic inf, input logic zero);
        bif.in_sign       = sign;
        bif.in_mant       = mant;
        bif.exp_res_tmp   = e10;
        bif.denorm_shift  = dsh;
        bif.prev_inf      = pinf;
        bif.prev_overflow = povf;
        bif.in_nan        = nan;
        bif.in_inf        = inf;
        bif.in_zero       = zero;
    endtask

    task automatic rand_beat();
        logic [23:0] ma, mb;
        int          e, k;
        ma = {1'b1, 23'($urandom)};
        mb = {1'b1, 23'($urandom)};
        bif.in_mant = 48'(ma) * 48'(mb);
        if ($urandom_range(7) == 0) bif.in_mant[22:0] = 23'h40_0000;
        k = int'($urandom_range(9));
        if (k < 6)      e = int'($urandom_range(254, 1));
        else if (k < 8) e = int'($urandom_range(60, 0)) - 60;
        else            e = int'($urandom_range(300, 240));
        bif.exp_res_tmp   = 10'(e);
        bif.prev_inf      = (e == 255);
        bif.prev_overflow = (e >= 256);
        bif.denorm_shift  = (e <= 0) ? 8'(1 - e) : 8'd0;
        bif.in_sign       = 1'($urandom);
        k = int'($urandom_range(19));
        bif.in_nan  = (k == 0);
        bif.in_inf  = (k == 1);
        bif.in_zero = (k == 2) || (k == 0 && $urandom_range(1) == 1);
    endtask

    task automatic send();
        int n0;
        n0 = acc_cnt;
        bif.in_valid = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == n0; i++) step();
        bif.in_valid = 1'b0;
        if (acc_cnt == n0) chk("send_timeout", 64'(acc_cnt - n0), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [34:0] want);
        send();
        drain();
        chk(tag, 64'(last_out), 64'(want));
    endtask

    initial begin
        int n0;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        set_beat(0, '0, '0, '0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
        chk("rst_outputs", 64'({bif.out_result, bif.out_overflow, bif.out_underflow,
                                bif.out_inexact}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        set_beat(0, 48'h9000_0000_0000, 10'h07F, 8'd0, 0, 0, 0, 0, 0);
        directed("t_1p5_squared", {32'h4010_0000, 3'b000});
        set_beat(1, 48'h4000_0000_0000, 10'h100, 8'd0, 0, 1, 0, 0, 0);
        directed("t_prev_overflow", {32'hFF80_0000, 3'b101});
        set_beat(0, 48'h4000_0000_0000, 10'h3FF, 8'd2, 0, 0, 0, 0, 0);
        directed("t_denorm_exact", {32'h0020_0000, 3'b000});
        set_beat(0, 48'h4000_0000_0001, 10'h3FF, 8'd2, 0, 0, 0, 0, 0);
        directed("t_denorm_inexact", {32'h0020_0000, 3'b011});
        set_beat(0, 48'h4000_0040_0000, 10'h07F, 8'd0, 0, 0, 0, 0, 0);
        directed("t_tie_even", {32'h3F80_0000, 3'b001});
        set_beat(0, 48'h4000_00C0_0000, 10'h07F, 8'd0, 0, 0, 0, 0, 0);
        directed("t_tie_odd_up", {32'h3F80_0002, 3'b001});
        set_beat(0, 48'h0000_0000_0000, 10'h000, 8'd0, 0, 0, 1, 0, 1);
        directed("t_nan_over_zero", {32'h7FC0_0000, 3'b000});
        set_beat(0, 48'h7FFF_FFC0_0000, 10'h0FE, 8'd0, 0, 0, 0, 0, 0);
        directed("t_round_to_ovf", {32'h7F80_0000, 3'b101});
        set_beat(1, 48'h8000_0000_0000, 10'h0FE, 8'd0, 0, 0, 0, 0, 0);
        directed("t_norm_shift_ovf", {32'hFF80_0000, 3'b101});
        set_beat(0, 48'h7FFF_FF80_0000, 10'h000, 8'd1, 0, 0, 0, 0, 0);
        directed("t_denorm_to_hidden", {32'h0080_0000, 3'b011});
        set_beat(1, 48'h4000_0000_0000, 10'h3C5, 8'd60, 0, 0, 0, 0, 0);
        directed("t_denorm_big_shift", {32'h8000_0000, 3'b011});
        set_beat(1, 48'h4000_0000_0000, 10'h050, 8'd0, 0, 0, 0, 1, 0);
        directed("t_inf", {32'hFF80_0000, 3'b000});

        // Backpressure: four back-to-back beats, output stalled for five cycles
        chk_lat = 1'b0;
        bif.out_ready = 1'b0;
        n0 = acc_cnt;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) bif.out_ready = 1'b1;
            if (acc_cnt - n0 < 4) begin
                rand_beat();
                bif.in_valid = 1'b1;
            end else begin
                bif.in_valid = 1'b0;
            end
            step();
            if (c >= 2 && c <= 4) begin
                chk("bp_in_ready", 64'(last_in_ready), 64'd0);
                chk("bp_accepted", 64'(acc_cnt - n0), 64'd2);
            end
        end
        bif.in_valid = 1'b0;
        drain();
        chk("bp_all_accepted", 64'(acc_cnt - n0), 64'd4);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rand_beat();
            bif.in_valid  = ($urandom_range(4) != 0);
            bif.out_ready = ($urandom_range(3) != 0);
            step();
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        drain();

        // Reset with both stages occupied
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b1;
        rand_beat();
        step();
        rand_beat();
        step();
        bif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bif.in_ready), 64'd1);
        chk("midrst_result", 64'(bif.out_result), 64'd0);
        exp_q.delete();
        acc_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst_idle", 64'(bif.out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
